// File: rtl/console_input_ctrl.sv
// console_input_ctrl
//   Frame-synchronous input conditioning for the Atari 2600 core. Buttons and
//   switches are synchronised and debounced, then presented to the core so
//   that they stay constant for a whole TIA frame (latched on each vsync rise).
//   A console RESET press is stretched over a minimum number of frames. Without
//   vsync activity the outputs fall back to following the debounced inputs.
//
// Ports
//   clk          pixel clock (only clock)
//   rst_n        asynchronous active-low reset
//   btn_raw[6:0] raw buttons {right, left, down, up, select, fire, reset}
//   sw_raw[3:0]  raw switches {sw4, sw3, sw2, sw1}
//   tia_vsync    vsync level from the core
//   ui_out[6:0]  to core ui_in: {right, left, down, up, select, fire, ~console_reset}
//   sw_out[3:0]  to core uio_in[3:0]
//   frame_strobe one-cycle pulse per accepted vsync edge
//   locked       1 while frame-locked, 0 while free-running
module console_input_ctrl #(
  parameter int DEBOUNCE_CYCLES   = 50000,
  parameter int RESET_HOLD_FRAMES = 4,
  parameter int VSYNC_TIMEOUT     = 1048576
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] btn_raw,
  input  logic [3:0] sw_raw,
  input  logic       tia_vsync,
  output logic [6:0] ui_out,
  output logic [3:0] sw_out,
  output logic       frame_strobe,
  output logic       locked
);

  localparam int NIN = 11;
  localparam int PW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int WW  = (VSYNC_TIMEOUT > 1) ? $clog2(VSYNC_TIMEOUT) : 1;
  localparam int HW  = (RESET_HOLD_FRAMES > 0) ? $clog2(RESET_HOLD_FRAMES + 1) : 1;

  localparam logic [PW-1:0] PRE_LAST  = PW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WW-1:0] WD_LAST   = WW'(VSYNC_TIMEOUT - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(RESET_HOLD_FRAMES);

  typedef enum logic {FREE = 1'b0, LOCKED = 1'b1} state_t;

  function automatic logic [HW-1:0] sat_dec(input logic [HW-1:0] v);
    return (v == '0) ? v : v - HW'(1);
  endfunction

  logic [NIN-1:0] raw_in;
  logic [NIN-1:0] sync_p0, sync_p1;
  logic           vs_p0, vs_p1, vs_p2;
  logic           vs_edge;
  logic [PW-1:0]  pre_cnt;
  logic           tick;
  logic [NIN-1:0] sh_p0, sh_p1;
  logic [NIN-1:0] db;
  logic [NIN-1:0] all_one, all_zero;
  logic [NIN-1:0] out_q;
  logic [WW-1:0]  wd_cnt;
  logic [HW-1:0]  hold_cnt;
  logic           console_reset;
  logic           load;
  logic           rst_rise;
  state_t         state, next_state;

  assign raw_in = {sw_raw, btn_raw};

  // ---- stage p0/p1: two-flop synchronisers; p2 is the vsync edge history ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      vs_p0   <= 1'b0;
      vs_p1   <= 1'b0;
      vs_p2   <= 1'b0;
    end else begin
      sync_p0 <= raw_in;
      sync_p1 <= sync_p0;
      vs_p0   <= tia_vsync;
      vs_p1   <= vs_p0;
      vs_p2   <= vs_p1;
    end
  end

  assign vs_edge = vs_p1 & ~vs_p2;

  // ---- debounce sample prescaler ----
  assign tick = (pre_cnt == PRE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else pre_cnt <= pre_cnt + PW'(1);
  end

  // ---- debounce: the 3-sample window is the incoming sample plus the two stored ones ----
  assign all_one  = sync_p1 & sh_p0 & sh_p1;
  assign all_zero = ~sync_p1 & ~sh_p0 & ~sh_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_p0 <= '0;
      sh_p1 <= '0;
      db    <= '0;
    end else if (tick) begin
      sh_p0 <= sync_p1;
      sh_p1 <= sh_p0;
      db    <= (db & ~all_zero) | all_one;
    end
  end

  // ---- frame lock FSM ----
  always_comb begin
    next_state = state;
    load       = 1'b0;
    case (state)
      FREE: begin
        load = 1'b1;
        if (vs_edge) next_state = LOCKED;
      end
      LOCKED: begin
        load = vs_edge;
        // An edge in the same cycle as the timeout keeps the lock.
        if (!vs_edge && (wd_cnt == WD_LAST)) next_state = FREE;
      end
      default: next_state = FREE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FREE;
    else state <= next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wd_cnt <= '0;
    else if (vs_edge || (state == FREE)) wd_cnt <= '0;
    else if (wd_cnt != WD_LAST) wd_cnt <= wd_cnt + WW'(1);
  end

  // ---- output latch, strobe and reset stretch ----
  assign rst_rise = load & db[0] & ~out_q[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      frame_strobe <= 1'b0;
      hold_cnt     <= '0;
    end else begin
      frame_strobe <= vs_edge;
      if (load) out_q <= db;
      // The hold only counts down on locked frames once the latched press has
      // been released, so a one-frame press stays asserted 1 + HOLD frames.
      if (rst_rise) hold_cnt <= HOLD_LOAD;
      else if ((state == LOCKED) && vs_edge && !out_q[0]) hold_cnt <= sat_dec(hold_cnt);
    end
  end

  assign console_reset = out_q[0] | (hold_cnt != '0);
  assign ui_out        = {out_q[6:1], ~console_reset};
  assign sw_out        = out_q[10:7];
  assign locked        = (state == LOCKED);

endmodule

// File: tb/tb_console_input_ctrl.sv
// Testbench for console_input_ctrl with DEBOUNCE_CYCLES=4, RESET_HOLD_FRAMES=2,
// VSYNC_TIMEOUT=64. Each vsync edge pushes the frame values it should latch;
// a monitor pops and compares whenever frame_strobe is presented.
module tb_console_input_ctrl;

  localparam int DEB  = 4;
  localparam int HOLD = 2;
  localparam int TMO  = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] btn_raw = '0;
  logic [3:0] sw_raw = '0;
  logic       tia_vsync = 1'b0;
  logic [6:0] ui_out;
  logic [3:0] sw_out;
  logic       frame_strobe;
  logic       locked;

  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q[$];

  console_input_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .RESET_HOLD_FRAMES(HOLD),
    .VSYNC_TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_raw(btn_raw),
    .sw_raw(sw_raw),
    .tia_vsync(tia_vsync),
    .ui_out(ui_out),
    .sw_out(sw_out),
    .frame_strobe(frame_strobe),
    .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Raise vsync at a negedge (cycle N); the strobe must appear after edge N+3.
  task automatic vs_edge(input logic [6:0] eu, input logic [3:0] es);
    exp_q.push_back({eu, es});
    tia_vsync = 1'b1;
    @(negedge clk);
    check("strobe_n1", frame_strobe, 0);
    @(negedge clk);
    check("strobe_n2", frame_strobe, 0);
    tia_vsync = 1'b0;
    @(negedge clk);
    check("strobe_n3", frame_strobe, 1);
    check("locked_at_strobe", locked, 1);
    @(negedge clk);
    check("strobe_width", frame_strobe, 0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && frame_strobe) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL strobe_unexpected: ui_out 0x%0h sw_out 0x%0h, none expected", ui_out, sw_out);
      end else begin
        logic [10:0] e;
        e = exp_q.pop_front();
        check("frame_ui", ui_out, e[10:4]);
        check("frame_sw", sw_out, e[3:0]);
      end
    end
  end

  initial begin
    logic seen;
    int   lat;
    int   cnt;

    // Reset with inputs toggling
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      btn_raw   = 7'($urandom);
      sw_raw    = 4'($urandom);
      tia_vsync = 1'($urandom);
      check("reset_ui", ui_out, 7'h01);
    end
    check("reset_sw", sw_out, 4'h0);
    check("reset_locked", locked, 0);
    check("reset_strobe", frame_strobe, 0);
    btn_raw   = '0;
    sw_raw    = '0;
    tia_vsync = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(30);
    check("idle_ui", ui_out, 7'h01);
    check("idle_locked", locked, 0);

    // Short fire pulse must be rejected
    seen = 1'b0;
    btn_raw[1] = 1'b1;
    for (int i = 0; i < 35; i++) begin
      if (i == 5) btn_raw[1] = 1'b0;
      @(negedge clk);
      if (ui_out[1]) seen = 1'b1;
    end
    check("glitch_fire", seen, 0);

    // Held fire reaches the output within 2 + 3*DEB + 1 cycles in FREE
    lat = 0;
    btn_raw[1] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ui_out[1]) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat == 0 || lat > 15) begin
      errors++;
      $display("FAIL fire_latency: got %0d cycles (0 = never), required 1..15", lat);
    end
    check("free_fire_ui", ui_out, 7'h03);
    check("free_locked", locked, 0);

    sw_raw = 4'b0101;
    step(20);
    check("free_sw", sw_out, 4'h5);

    // First vsync edge locks
    check("locked_before_edge", locked, 0);
    vs_edge(7'h03, 4'h5);

    // Mid-frame changes stay hidden until the next strobe
    btn_raw[3] = 1'b1;
    sw_raw = 4'hC;
    step(20);
    check("up_midframe_ui", ui_out, 7'h03);
    check("sw_midframe", sw_out, 4'h5);
    vs_edge(7'h0B, 4'hC);

    // One-frame console reset press: low for 3 strobe periods
    btn_raw[0] = 1'b1;
    step(20);
    check("reset_press_midframe", ui_out, 7'h0B);
    vs_edge(7'h0A, 4'hC);
    btn_raw[0] = 1'b0;
    step(20);
    check("stretch_latched", ui_out, 7'h0A);
    vs_edge(7'h0A, 4'hC);
    step(20);
    check("stretch_hold1", ui_out, 7'h0A);
    vs_edge(7'h0A, 4'hC);
    step(20);
    check("stretch_hold2", ui_out, 7'h0A);
    vs_edge(7'h0B, 4'hC);

    // Watchdog: locked falls 64 cycles after the last strobe
    cnt = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cnt++;
      if (!locked) break;
    end
    check("watchdog_cycles", cnt, 64);
    step(2);
    check("free_after_wd_ui", ui_out, 7'h0B);
    check("free_after_wd_sw", sw_out, 4'hC);
    btn_raw[1] = 1'b0;
    step(20);
    check("free_follow_fire", ui_out, 7'h09);
    vs_edge(7'h09, 4'hC);

    // Asynchronous reset mid-frame
    step(10);
    check("pre_areset_ui", ui_out, 7'h09);
    check("pre_areset_locked", locked, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_ui", ui_out, 7'h01);
    check("areset_sw", sw_out, 4'h0);
    check("areset_locked", locked, 0);
    check("areset_strobe", frame_strobe, 0);
    step(3);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_areset_ui", ui_out, 7'h01);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
